// File: rtl/traffic_controller_n.sv
// traffic_controller_n: fixed-time multi-phase signal controller with a tick
// divider, per-phase pedestrian extension and a night-flash mode.
module traffic_controller_n #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TICK_HZ   = 1,
  parameter int N_PHASES  = 4,
  parameter int GREEN_T   = 10,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int PED_EXT_T = 5,
  localparam int PW = (N_PHASES > 1) ? $clog2(N_PHASES) : 1
) (
  input  logic                    clk_100MHz,
  input  logic                    reset,
  input  logic [N_PHASES-1:0]     ped_req,
  input  logic                    flash_mode,
  output logic [3*N_PHASES-1:0]   lights,
  output logic [N_PHASES-1:0]     walk,
  output logic [PW-1:0]           phase_idx,
  output logic                    tick
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int DW    = $clog2(DIV);
  localparam int GX_T  = GREEN_T + PED_EXT_T;
  localparam int MAX_A = (GX_T > YELLOW_T) ? GX_T : YELLOW_T;
  localparam int MAX_T = (MAX_A > ALLRED_T) ? MAX_A : ALLRED_T;
  localparam int TW    = $clog2(MAX_T + 1);

  localparam logic [2:0] C_RED = 3'b100;
  localparam logic [2:0] C_YEL = 3'b010;
  localparam logic [2:0] C_GRN = 3'b001;
  localparam logic [2:0] C_OFF = 3'b000;

  typedef enum logic [1:0] {ALLRED, GREEN, YELLOW, FLASH} state_t;

  state_t                state;
  logic [DW-1:0]         div_cnt;
  logic [TW-1:0]         timer;
  logic [N_PHASES-1:0]   pending;
  logic [N_PHASES-1:0]   pending_nxt;
  logic [N_PHASES-1:0]   idx_mask;
  logic                  flash_bit;
  logic                  expire;
  logic                  green_entry;
  logic                  ext;

  assign tick = (div_cnt == DW'(DIV - 1));

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) div_cnt <= '0;
    else       div_cnt <= tick ? '0 : div_cnt + 1'b1;
  end

  // A request landing on the green-entry cycle of its own phase is dropped by the clear.
  always_comb begin
    idx_mask    = N_PHASES'(1) << phase_idx;
    expire      = tick && (timer == TW'(1));
    green_entry = expire && (state == ALLRED) && !flash_mode;
    ext         = |(pending & idx_mask);
    pending_nxt = (pending | ped_req) & ~(green_entry ? idx_mask : '0);
  end

  function automatic logic [3*N_PHASES-1:0] paint(input logic [PW-1:0] idx,
                                                  input logic [2:0] active,
                                                  input logic [2:0] others);
    logic [3*N_PHASES-1:0] out;
    out = '0;
    for (int unsigned p = 0; p < N_PHASES; p++)
      out[3*p +: 3] = (PW'(p) == idx) ? active : others;
    return out;
  endfunction

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state     <= ALLRED;
      timer     <= TW'(ALLRED_T);
      phase_idx <= '0;
      pending   <= '0;
      flash_bit <= 1'b1;
      lights    <= paint('0, C_RED, C_RED);
      walk      <= '0;
    end else begin
      pending <= pending_nxt;
      if (tick) begin
        unique case (state)
          ALLRED: begin
            if (expire) begin
              if (flash_mode) begin
                state     <= FLASH;
                flash_bit <= 1'b1;
                lights    <= paint('0, C_YEL, C_YEL);
              end else begin
                state  <= GREEN;
                timer  <= ext ? TW'(GX_T) : TW'(GREEN_T);
                lights <= paint(phase_idx, C_GRN, C_RED);
                walk   <= ext ? idx_mask : '0;
              end
            end else begin
              timer <= timer - 1'b1;
            end
          end
          GREEN: begin
            if (expire) begin
              state  <= YELLOW;
              timer  <= TW'(YELLOW_T);
              lights <= paint(phase_idx, C_YEL, C_RED);
              walk   <= '0;
            end else begin
              timer <= timer - 1'b1;
            end
          end
          YELLOW: begin
            if (expire) begin
              state     <= ALLRED;
              timer     <= TW'(ALLRED_T);
              phase_idx <= (phase_idx == PW'(N_PHASES - 1)) ? '0 : phase_idx + 1'b1;
              lights    <= paint('0, C_RED, C_RED);
            end else begin
              timer <= timer - 1'b1;
            end
          end
          FLASH: begin
            if (!flash_mode) begin
              state     <= ALLRED;
              timer     <= TW'(ALLRED_T);
              phase_idx <= '0;
              flash_bit <= 1'b1;
              lights    <= paint('0, C_RED, C_RED);
            end else begin
              flash_bit <= ~flash_bit;
              lights    <= flash_bit ? paint('0, C_OFF, C_OFF) : paint('0, C_YEL, C_YEL);
            end
          end
          default: state <= ALLRED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_traffic_controller_n.sv
// Bench for traffic_controller_n: tick-level behavioural model compared every
// cycle, plus literal checks on green durations, flash and reset behaviour.
module tb_traffic_controller_n;

  localparam int DIV = 10;
  localparam int NP  = 2;
  localparam int GT  = 3;
  localparam int YT  = 2;
  localparam int AT  = 1;
  localparam int ET  = 2;

  localparam logic [5:0] L_RED = 6'b100100;
  localparam logic [5:0] L_G0  = 6'b100001;
  localparam logic [5:0] L_Y1  = 6'b010100;
  localparam logic [5:0] L_FY  = 6'b010010;

  logic       clk_100MHz = 1'b0;
  logic       reset      = 1'b1;
  logic [1:0] ped_req    = '0;
  logic       flash_mode = 1'b0;
  logic [5:0] lights;
  logic [1:0] walk;
  logic [0:0] phase_idx;
  logic       tick;

  logic [2:0] ped3   = '0;
  logic       flash3 = 1'b0;
  logic [8:0] lights3;
  logic [2:0] walk3;
  logic [1:0] phase_idx3;
  logic       tick3;

  traffic_controller_n #(.CLK_HZ(10), .TICK_HZ(1), .N_PHASES(2), .GREEN_T(3),
                         .YELLOW_T(2), .ALLRED_T(1), .PED_EXT_T(2)) dut (
    .clk_100MHz(clk_100MHz), .reset(reset), .ped_req(ped_req), .flash_mode(flash_mode),
    .lights(lights), .walk(walk), .phase_idx(phase_idx), .tick(tick));

  traffic_controller_n #(.CLK_HZ(10), .TICK_HZ(1), .N_PHASES(3), .GREEN_T(3),
                         .YELLOW_T(2), .ALLRED_T(1), .PED_EXT_T(2)) dut3 (
    .clk_100MHz(clk_100MHz), .reset(reset), .ped_req(ped3), .flash_mode(flash3),
    .lights(lights3), .walk(walk3), .phase_idx(phase_idx3), .tick(tick3));

  initial forever #5 clk_100MHz = ~clk_100MHz;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: which interval we are in, ticks left in it, phase, pending requests.
  localparam int M_AR = 0, M_G = 1, M_Y = 2, M_F = 3;
  int         m_cyc, m_st, m_left, m_ph;
  logic [1:0] m_pend, m_walk;
  logic       m_fl;

  task automatic m_reset();
    m_cyc = 0; m_st = M_AR; m_left = AT; m_ph = 0;
    m_pend = '0; m_walk = '0; m_fl = 1'b1;
  endtask

  task automatic m_step();
    logic [1:0] old;
    old    = m_pend;
    m_pend = m_pend | ped_req;
    if (m_cyc % DIV == DIV - 1) begin
      case (m_st)
        M_AR: begin
          m_left--;
          if (m_left == 0) begin
            if (flash_mode) begin
              m_st = M_F; m_fl = 1'b1;
            end else begin
              m_st   = M_G;
              m_left = GT + (old[m_ph] ? ET : 0);
              m_walk = old[m_ph] ? (2'b01 << m_ph) : 2'b00;
              m_pend[m_ph] = 1'b0;
            end
          end
        end
        M_G: begin
          m_left--;
          if (m_left == 0) begin m_st = M_Y; m_left = YT; m_walk = '0; end
        end
        M_Y: begin
          m_left--;
          if (m_left == 0) begin m_st = M_AR; m_left = AT; m_ph = (m_ph + 1) % NP; end
        end
        default: begin
          if (!flash_mode) begin m_st = M_AR; m_left = AT; m_ph = 0; end
          else m_fl = !m_fl;
        end
      endcase
    end
    m_cyc++;
  endtask

  function automatic logic [5:0] m_lights();
    logic [5:0] r;
    r = '0;
    for (int p = 0; p < NP; p++) begin
      case (m_st)
        M_G:     r[3*p +: 3] = (p == m_ph) ? 3'b001 : 3'b100;
        M_Y:     r[3*p +: 3] = (p == m_ph) ? 3'b010 : 3'b100;
        M_F:     r[3*p +: 3] = m_fl ? 3'b010 : 3'b000;
        default: r[3*p +: 3] = 3'b100;
      endcase
    end
    return r;
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge clk_100MHz or posedge reset);
      if (reset) m_reset();
      else       m_step();
    end
  end

  // Green-interval log (phase, ticks shown green, walk at start, walk steady).
  int         q_ph[$], q_len[$];
  logic [1:0] q_w[$];
  logic       q_c[$];
  logic [1:0] q3[$];
  logic       run[2];
  int         glen[2];
  logic [1:0] gw[2];
  logic       gc[2];
  logic [5:0] prev_l = L_RED;
  logic [1:0] prev3  = '0;

  initial begin
    run[0] = 1'b0; run[1] = 1'b0;
    forever begin
      @(negedge clk_100MHz);
      chk("tick", 32'(tick), 32'(!reset && (m_cyc % DIV == DIV - 1)));
      chk("lights", 32'(lights), 32'(m_lights()));
      chk("walk", 32'(walk), 32'(m_walk));
      chk("phase_idx", 32'(phase_idx), 32'(m_ph));
      if (m_st != M_F) begin
        int nr;
        nr = 0;
        for (int p = 0; p < NP; p++) if (lights[3*p +: 3] !== 3'b100) nr++;
        chk("one_nonred", 32'(nr <= 1), 32'd1);
      end
      for (int p = 0; p < NP; p++) begin
        chk("green_to_red", 32'(prev_l[3*p +: 3] == 3'b001 && lights[3*p +: 3] == 3'b100), 32'd0);
        if (reset) run[p] = 1'b0;
        else if (lights[3*p +: 3] == 3'b001) begin
          if (!run[p]) begin run[p] = 1'b1; glen[p] = 0; gw[p] = walk; gc[p] = 1'b1; end
          if (tick) glen[p]++;
          if (walk !== gw[p]) gc[p] = 1'b0;
        end else if (run[p]) begin
          run[p] = 1'b0;
          q_ph.push_back(p); q_len.push_back(glen[p]); q_w.push_back(gw[p]); q_c.push_back(gc[p]);
        end
      end
      prev_l = lights;
      if (!reset && phase_idx3 != prev3) q3.push_back(phase_idx3);
      prev3 = phase_idx3;
    end
  end

  task automatic wait_lights(input logic [5:0] want, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk_100MHz);
      if (lights === want) break;
    end
  endtask

  task automatic wait_tick(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk_100MHz);
      if (tick) break;
    end
    chk("tick_seen", 32'(tick), 32'd1);
  endtask

  task automatic wait_q(input int n, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk_100MHz);
      if (q_len.size() >= n) break;
    end
  endtask

  task automatic first_tick(input string name);
    int n;
    n = 0;
    while (n < 20) begin
      @(negedge clk_100MHz);
      n++;
      if (tick) break;
    end
    chk(name, 32'(n), 32'(DIV - 1));
  endtask

  task automatic chk_log(input int i, input int ph, input int len, input logic [1:0] w);
    if (i >= q_len.size()) chk("green_log_missing", 32'(q_len.size()), 32'(i + 1));
    else begin
      chk("green_phase", 32'(q_ph[i]), 32'(ph));
      chk("green_len", 32'(q_len[i]), 32'(len));
      chk("green_walk", 32'(q_w[i]), 32'(w));
      chk("green_walk_steady", 32'(q_c[i]), 32'd1);
    end
  endtask

  initial begin
    int base;
    repeat (3) @(negedge clk_100MHz);
    #1;
    chk("rst_lights", 32'(lights), 32'(L_RED));
    chk("rst_walk", 32'(walk), 32'd0);
    chk("rst_idx", 32'(phase_idx), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_lights3", 32'(lights3), 32'h124);
    #1 reset = 1'b0;

    // Rising edges after release until the first tick: DIV-1.
    first_tick("first_tick_edges");
    chk("allred_first", 32'(lights), 32'(L_RED));
    @(negedge clk_100MHz);
    chk("g0_after_first_tick", 32'(lights), 32'(L_G0));
    #2 ped_req = 2'b10;
    @(negedge clk_100MHz); #2 ped_req = 2'b00;
    @(negedge clk_100MHz); #2 ped_req = 2'b01;
    @(negedge clk_100MHz); #2 ped_req = 2'b00;
    wait_q(4, 1000);
    chk_log(0, 0, 3, 2'b00);
    chk_log(1, 1, 5, 2'b10);
    chk_log(2, 0, 5, 2'b01);
    chk_log(3, 1, 3, 2'b00);

    wait_lights(L_G0, 400);
    chk("reach_g0_for_flash", 32'(lights), 32'(L_G0));
    #2 flash_mode = 1'b1;
    wait_lights(L_FY, 400);
    chk("flash_on", 32'(lights), 32'(L_FY));
    base = q_len.size();
    wait_tick(20);
    @(negedge clk_100MHz);
    chk("flash_dark", 32'(lights), 32'd0);
    #2 ped_req = 2'b10;
    @(negedge clk_100MHz); #2 ped_req = 2'b00;
    wait_tick(20);
    @(negedge clk_100MHz);
    chk("flash_yellow", 32'(lights), 32'(L_FY));
    #2 flash_mode = 1'b0;
    wait_lights(L_RED, 40);
    chk("flash_exit_red", 32'(lights), 32'(L_RED));
    chk("flash_exit_idx", 32'(phase_idx), 32'd0);
    wait_q(base + 2, 600);
    chk_log(base, 0, 3, 2'b00);
    chk_log(base + 1, 1, 5, 2'b10);

    wait_lights(L_Y1, 200);
    chk("reach_y1", 32'(lights), 32'(L_Y1));
    @(negedge clk_100MHz);
    #2 reset = 1'b1;
    #1;
    chk("midy_rst_lights", 32'(lights), 32'(L_RED));
    chk("midy_rst_walk", 32'(walk), 32'd0);
    chk("midy_rst_idx", 32'(phase_idx), 32'd0);
    chk("midy_rst_tick", 32'(tick), 32'd0);
    repeat (2) @(negedge clk_100MHz);
    #2 reset = 1'b0;
    base = q_len.size();
    q3.delete();
    first_tick("restart_first_tick");
    for (int k = 0; k < 500 && q3.size() < 6; k++) @(negedge clk_100MHz);
    chk("q3_len", 32'(q3.size()), 32'd6);
    for (int i = 0; i < 6 && i < q3.size(); i++)
      chk("n3_phase_seq", 32'(q3[i]), 32'((i + 1) % 3));
    chk_log(base, 0, 3, 2'b00);
    chk_log(base + 1, 1, 3, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_controller_n.md
TRAFFIC_CONTROLLER_N -- requirements
Module: traffic_controller_n

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 1, timing tick rate in Hz; DIV = CLK_HZ/TICK_HZ, integer, DIV >= 2.
REQ-003 SHALL have parameter N_PHASES, default 4, number of signal phases (2..8).
REQ-004 SHALL have parameters GREEN_T = 10, YELLOW_T = 3, ALLRED_T = 1 and PED_EXT_T = 5, durations in ticks, each >= 1.
REQ-005 SHALL have port clk_100MHz, input, width 1, single clock for all logic; rising edge.
REQ-006 SHALL have port reset, input, width 1, asynchronous, active-high; already debounced externally.
REQ-007 SHALL have port ped_req, input, width N_PHASES, one-cycle or level pedestrian request per phase; synchronous to clk_100MHz.
REQ-008 SHALL have port flash_mode, input, width 1, night-flash request; synchronous.
REQ-009 SHALL have port lights, output, width 3*N_PHASES; phase p drives bits [3p+2:3p] as {red, yellow, green}.
REQ-010 SHALL have port walk, output, width N_PHASES, pedestrian walk indication per phase.
REQ-011 SHALL have port phase_idx, output, width clog2(N_PHASES) (min 1), index of the active phase.
REQ-012 SHALL have port tick, output, width 1, one-cycle timing strobe.

Function
REQ-013 Divider counts 0..DIV-1 and wraps; tick = 1 exactly in the cycle the count equals DIV-1, so the first tick falls DIV cycles after reset release.
REQ-014 FSM states are ALLRED, GREEN, YELLOW and FLASH; a timer is loaded on state entry and decrements on each tick.
REQ-015 Each state lasts exactly its loaded duration in ticks: the transition occurs on the tick at which the timer = 1.
REQ-016 Timer width is clog2(max duration + 1); the timer never underflows.
REQ-017 ALLRED: all phases red; at expiry -> GREEN of phase_idx, unless flash_mode = 1, then -> FLASH.
REQ-018 GREEN loads GREEN_T, or GREEN_T + PED_EXT_T if pending[phase_idx] is set on entry.
REQ-019 In GREEN, the active phase shows green and all others red.
REQ-020 At GREEN expiry -> YELLOW, which loads YELLOW_T; the active phase shows yellow and others red.
REQ-021 At YELLOW expiry -> ALLRED; phase_idx increments, wrapping N_PHASES-1 -> 0.
REQ-022 Pending flags: pending[p] is set on any cycle where ped_req[p] = 1; multiple simultaneous requests are all latched.
REQ-023 pending[phase_idx] is cleared on GREEN entry, and walk[phase_idx] = 1 for the whole of that GREEN.
REQ-024 A request for the phase currently in GREEN/YELLOW is held for its next green; it does not extend the current green.
REQ-025 If a set and a clear of the same pending bit coincide (GREEN entry cycle), the clear wins.
REQ-026 walk = 0 in YELLOW, ALLRED and FLASH.
REQ-027 flash_mode is sampled only at ALLRED expiry; GREEN/YELLOW always complete first.
REQ-028 FLASH: all phases show yellow when a flash bit = 1 and all-dark (000) when 0; the flash bit toggles on every tick and starts at 1.
REQ-029 In FLASH, the tick on which flash_mode = 0 -> ALLRED with ALLRED_T, phase_idx = 0, and pending flags kept.
REQ-030 All outputs except tick are registered; they change on the clock edge ending the tick cycle.
REQ-031 At most one phase is non-red outside FLASH at any time; green never goes directly to red.

Reset
REQ-032 Asserting reset SHALL asynchronously force: divider = 0, state = ALLRED, timer = ALLRED_T, phase_idx = 0, pending = 0, flash bit = 1.
REQ-033 During reset, outputs are lights = all phases 100, walk = 0, tick = 0; reset mid-state aborts the state immediately with no yellow.
REQ-034 Operation restarts at the first clock edge after reset deasserts.

Verification (CLK_HZ=10, TICK_HZ=1, N_PHASES=2, GREEN_T=3, YELLOW_T=2, ALLRED_T=1, PED_EXT_T=2)
REQ-035 Release reset, no requests -> tick at cycles 10, 20, ...; phase0 all-red ALLRED for 1 tick, green 3, yellow 2; then phase 1 green; lights never shows two greens.
REQ-036 Pulse ped_req = 2'b10 during phase-0 green -> phase-1 green lasts 5 ticks with walk = 2'b10 throughout; next phase-1 green lasts 3 ticks.
REQ-037 ped_req[0] pulsed during phase-0 green -> current green stays 3 ticks; the next phase-0 green is 5 ticks with walk[0] = 1.
REQ-038 flash_mode = 1 during GREEN -> GREEN and YELLOW complete, ALLRED, then FLASH with lights = 010/010 toggling to 000/000 each tick; drop flash_mode -> ALLRED, phase_idx = 0.
REQ-039 Assert reset mid-YELLOW -> same cycle: lights = 100/100, walk = 0, phase_idx = 0; release -> sequence restarts as in REQ-035.
REQ-040 N_PHASES=3: run for 2 full cycles -> phase_idx goes 0,1,2,0,1,2 and wraps cleanly.
